// File: rtl/rcv_pkg.sv
// rcv_pkg: shared block type and packer state encoding for the receive buffer.
package rcv_pkg;
    localparam int BLOCK_W = 64;
    typedef logic [BLOCK_W-1:0] block_t;
    typedef enum logic {FILL, PEND} packer_state_t;
endpackage

// File: rtl/rcv_block_fifo_if.sv
// rcv_block_fifo_if: receiver byte handshake plus MCU-facing block queue signals.
interface rcv_block_fifo_if
    import rcv_pkg::*;
#(
    parameter int BLOCK_BYTES = 8,
    parameter int DEPTH = 4
);
    localparam int BW = 8 * BLOCK_BYTES;
    localparam int CW = $clog2(DEPTH + 1);
    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ready;
    logic          rx_flush;
    logic          rcv_deq;
    logic [BW-1:0] rx_block;
    logic          emptyRx;
    logic          fullRx;
    logic [CW-1:0] count;
    logic          underflow_err;
    modport master (
        output rx_byte, rx_valid, rx_flush, rcv_deq,
        input  rx_ready, rx_block, emptyRx, fullRx, count, underflow_err
    );
    modport slave (
        input  rx_byte, rx_valid, rx_flush, rcv_deq,
        output rx_ready, rx_block, emptyRx, fullRx, count, underflow_err
    );
endinterface

// File: rtl/rcv_block_fifo_fifo.sv
// block_fifo: synchronous circular FIFO with fall-through head and registered underflow pulse.
module block_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          underflow
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          underflow_q, do_rd, do_wr;
    assign empty = count_q == '0;
    assign full = count_q == CW'(DEPTH);
    assign do_rd = rd_en & !empty;
    // a pop frees the slot the same edge, so a full FIFO can still accept
    assign do_wr = wr_en & (!full | do_rd);
    assign count_d = count_q + CW'(do_wr) - CW'(do_rd);
    assign rd_data = mem_q[rd_ptr_q];
    assign count = count_q;
    assign underflow = underflow_q;
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q <= '0;
            underflow_q <= 1'b0;
            mem_q <= '{default: '0};
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            underflow_q <= rd_en & empty;
        end
    end
endmodule

// File: rtl/rcv_block_fifo.sv
// rcv_block_fifo: packs received bytes MSB-first into blocks and queues them for the MCU.
module rcv_block_fifo
    import rcv_pkg::*;
#(
    parameter int BLOCK_BYTES = 8,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    rcv_block_fifo_if.slave bus
);
    localparam int BW = 8 * BLOCK_BYTES;
    localparam int BCW = BLOCK_BYTES > 1 ? $clog2(BLOCK_BYTES) : 1;
    packer_state_t  state_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [BW-1:0]  pack_q;
    logic           clr, can_write, wr_en, last;
    assign clr = reset | bus.rx_flush;
    assign can_write = !bus.fullRx | bus.rcv_deq;
    assign wr_en = (state_q == PEND) & can_write & !clr;
    assign last = byte_cnt_q == BCW'(BLOCK_BYTES - 1);
    assign bus.rx_ready = state_q == FILL;
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= FILL;
            byte_cnt_q <= '0;
            pack_q <= '0;
        end else if (state_q == FILL) begin
            if (bus.rx_valid) begin
                pack_q[BW-1-8*int'(byte_cnt_q) -: 8] <= bus.rx_byte;
                byte_cnt_q <= last ? '0 : byte_cnt_q + 1'b1;
                state_q <= last ? PEND : FILL;
            end
        end else if (can_write) begin
            state_q <= FILL;
        end
    end
    block_fifo #(.W(BW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst(reset),
        .clr(bus.rx_flush),
        .wr_en(wr_en),
        .wr_data(pack_q),
        .rd_en(bus.rcv_deq),
        .rd_data(bus.rx_block),
        .count(bus.count),
        .empty(bus.emptyRx),
        .full(bus.fullRx),
        .underflow(bus.underflow_err)
    );
endmodule

// File: tb/tb_rcv_block_fifo.sv
// tb_rcv_block_fifo: directed scenarios plus a randomized run against a queue-based model.
module tb_rcv_block_fifo;
    import rcv_pkg::*;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    block_t mq[$];
    block_t part;
    int nb;
    bit pend;
    bit uf_exp;
    always #5 clk = ~clk;
    rcv_block_fifo_if #(.BLOCK_BYTES(8), .DEPTH(DEPTH)) bus ();
    rcv_block_fifo #(.BLOCK_BYTES(8), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
    // one clock edge with the given inputs; the model advances in transaction terms
    task automatic cycle(input bit v, input logic [7:0] b, input bit d, input bit f);
        int sz0;
        bus.rx_valid = v;
        bus.rx_byte = b;
        bus.rcv_deq = d;
        bus.rx_flush = f;
        @(posedge clk);
        if (reset || f) begin
            mq.delete();
            nb = 0;
            pend = 0;
            part = '0;
            uf_exp = 0;
        end else begin
            sz0 = mq.size();
            uf_exp = d && sz0 == 0;
            if (d && sz0 > 0) void'(mq.pop_front());
            if (pend) begin
                if (sz0 < DEPTH || d) begin
                    mq.push_back(part);
                    pend = 0;
                    nb = 0;
                end
            end else if (v) begin
                part = {part[55:0], b};
                nb++;
                if (nb == 8) pend = 1;
            end
        end
        #1;
        bus.rx_valid = 1'b0;
        bus.rcv_deq = 1'b0;
        bus.rx_flush = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b);
        bit acc;
        for (int t = 0; t < 20; t++) begin
            acc = bus.rx_ready;
            cycle(1, b, 0, 0);
            if (acc) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL send_byte: byte %h not accepted, rx_ready stuck at %b, want 1 within 20 cycles", b, bus.rx_ready);
    endtask
    task automatic send_block(input block_t blk);
        for (int i = 0; i < 8; i++) send_byte(blk[63-8*i -: 8]);
    endtask
    task automatic test_reset();
        reset = 1'b1;
        cycle(0, 8'h00, 0, 0);
        cycle(0, 8'h00, 0, 0);
        reset = 1'b0;
        n_cmp += 6;
        if (bus.emptyRx !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.emptyRx); end
        if (bus.fullRx !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.fullRx); end
        if (bus.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", bus.rx_ready); end
        if (bus.rx_block !== 64'h0) begin n_bad++; $display("FAIL reset_block: got %h want 0", bus.rx_block); end
        if (bus.underflow_err !== 1'b0) begin n_bad++; $display("FAIL reset_uf: got %b want 0", bus.underflow_err); end
    endtask
    task automatic test_single_block();
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        n_cmp += 2;
        if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL single_pend_ready: got %b want 0", bus.rx_ready); end
        if (bus.emptyRx !== 1'b1) begin n_bad++; $display("FAIL single_latency_empty: got %b want 1", bus.emptyRx); end
        cycle(0, 8'h00, 0, 0);
        n_cmp += 3;
        if (bus.count !== 3'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.count); end
        if (bus.emptyRx !== 1'b0) begin n_bad++; $display("FAIL single_empty: got %b want 0", bus.emptyRx); end
        if (bus.rx_block !== 64'h0102030405060708) begin n_bad++; $display("FAIL single_block: got %h want 0102030405060708", bus.rx_block); end
        cycle(0, 8'h00, 1, 0);
        n_cmp++;
        if (bus.emptyRx !== 1'b1) begin n_bad++; $display("FAIL single_deq_empty: got %b want 1", bus.emptyRx); end
    endtask
    task automatic test_fill_backpressure();
        block_t blk[5];
        for (int k = 0; k < 5; k++) begin
            blk[k] = {$urandom, $urandom};
            send_block(blk[k]);
        end
        cycle(0, 8'h00, 0, 0);
        n_cmp += 4;
        if (bus.fullRx !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", bus.fullRx); end
        if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_count: got %0d want 4", bus.count); end
        if (bus.rx_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready: got %b want 0", bus.rx_ready); end
        if (bus.rx_block !== blk[0]) begin n_bad++; $display("FAIL fill_head: got %h want %h", bus.rx_block, blk[0]); end
        cycle(0, 8'h00, 1, 0);
        n_cmp += 4;
        if (bus.fullRx !== 1'b1) begin n_bad++; $display("FAIL fill_deq_full: got %b want 1", bus.fullRx); end
        if (bus.count !== 3'd4) begin n_bad++; $display("FAIL fill_deq_count: got %0d want 4", bus.count); end
        if (bus.rx_block !== blk[1]) begin n_bad++; $display("FAIL fill_deq_head: got %h want %h", bus.rx_block, blk[1]); end
        if (bus.rx_ready !== 1'b1) begin n_bad++; $display("FAIL fill_deq_ready: got %b want 1", bus.rx_ready); end
        for (int k = 1; k < 5; k++) begin
            n_cmp++;
            if (bus.rx_block !== blk[k]) begin n_bad++; $display("FAIL fill_drain_%0d: got %h want %h", k, bus.rx_block, blk[k]); end
            cycle(0, 8'h00, 1, 0);
        end
        n_cmp++;
        if (bus.emptyRx !== 1'b1) begin n_bad++; $display("FAIL fill_drained_empty: got %b want 1", bus.emptyRx); end
    endtask
    task automatic test_wrap();
        block_t blk;
        for (int k = 0; k < 10; k++) begin
            blk = {$urandom, $urandom};
            send_block(blk);
            for (int t = 0; t < 4 && bus.emptyRx; t++) cycle(0, 8'h00, 0, 0);
            n_cmp += 2;
            if (bus.rx_block !== blk) begin n_bad++; $display("FAIL wrap_block_%0d: got %h want %h", k, bus.rx_block, blk); end
            if (bus.count !== 3'd1) begin n_bad++; $display("FAIL wrap_count_%0d: got %0d want 1", k, bus.count); end
            cycle(0, 8'h00, 1, 0);
            n_cmp++;
            if (bus.emptyRx !== 1'b1) begin n_bad++; $display("FAIL wrap_empty_%0d: got %b want 1", k, bus.emptyRx); end
        end
    endtask
    task automatic test_underflow();
        block_t blk;
        cycle(0, 8'h00, 1, 0);
        n_cmp += 2;
        if (bus.underflow_err !== 1'b1) begin n_bad++; $display("FAIL uf_pulse: got %b want 1", bus.underflow_err); end
        if (bus.count !== 3'd0) begin n_bad++; $display("FAIL uf_count: got %0d want 0", bus.count); end
        cycle(0, 8'h00, 0, 0);
        n_cmp++;
        if (bus.underflow_err !== 1'b0) begin n_bad++; $display("FAIL uf_one_cycle: got %b want 0", bus.underflow_err); end
        blk = {$urandom, $urandom};
        send_block(blk);
        cycle(0, 8'h00, 1, 0);
        n_cmp += 3;
        if (bus.count !== 3'd1) begin n_bad++; $display("FAIL uf_wr_deq_count: got %0d want 1", bus.count); end
        if (bus.underflow_err !== 1'b1) begin n_bad++; $display("FAIL uf_wr_deq_pulse: got %b want 1", bus.underflow_err); end
        if (bus.rx_block !== blk) begin n_bad++; $display("FAIL uf_wr_deq_block: got %h want %h", bus.rx_block, blk); end
        cycle(0, 8'h00, 1, 0);
    endtask
    task automatic test_flush();
        send_block({$urandom, $urandom});
        cycle(0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        cycle(0, 8'h00, 0, 1);
        n_cmp += 3;
        if (bus.count !== 3'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", bus.count); end
        if (bus.emptyRx !== 1'b1) begin n_bad++; $display("FAIL flush_empty: got %b want 1", bus.emptyRx); end
        if (bus.rx_block !== 64'h0) begin n_bad++; $display("FAIL flush_block: got %h want 0", bus.rx_block); end
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
        cycle(0, 8'h00, 0, 0);
        n_cmp += 2;
        if (bus.count !== 3'd1) begin n_bad++; $display("FAIL flush_after_count: got %0d want 1", bus.count); end
        if (bus.rx_block !== 64'hA0A1A2A3A4A5A6A7) begin n_bad++; $display("FAIL flush_after_block: got %h want a0a1a2a3a4a5a6a7", bus.rx_block); end
        cycle(0, 8'h00, 1, 0);
    endtask
    task automatic test_random();
        bit v, d, f;
        for (int i = 0; i < 600; i++) begin
            v = $urandom_range(0, 3) != 0;
            d = $urandom_range(0, 7) < (i < 300 ? 1 : 4);
            f = $urandom_range(0, 79) == 0;
            cycle(v, 8'($urandom), d, f);
            n_cmp += 5;
            if (bus.count !== 3'(mq.size())) begin n_bad++; $display("FAIL rand_count@%0d: got %0d want %0d", i, bus.count, mq.size()); end
            if (bus.emptyRx !== (mq.size() == 0)) begin n_bad++; $display("FAIL rand_empty@%0d: got %b want %b", i, bus.emptyRx, mq.size() == 0); end
            if (bus.fullRx !== (mq.size() == DEPTH)) begin n_bad++; $display("FAIL rand_full@%0d: got %b want %b", i, bus.fullRx, mq.size() == DEPTH); end
            if (bus.rx_ready !== !pend) begin n_bad++; $display("FAIL rand_ready@%0d: got %b want %b", i, bus.rx_ready, !pend); end
            if (bus.underflow_err !== uf_exp) begin n_bad++; $display("FAIL rand_uf@%0d: got %b want %b", i, bus.underflow_err, uf_exp); end
            if (mq.size() > 0) begin
                n_cmp++;
                if (bus.rx_block !== mq[0]) begin n_bad++; $display("FAIL rand_head@%0d: got %h want %h", i, bus.rx_block, mq[0]); end
            end
        end
    endtask
    initial begin
        bus.rx_byte = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_flush = 1'b0;
        bus.rcv_deq = 1'b0;
        test_reset();
        test_single_block();
        test_fill_backpressure();
        test_wrap();
        test_underflow();
        test_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end
endmodule
